// File: rtl/logic_unit_pkg.sv
// Shared types and helpers for the pipelined logic unit.
// Op encoding and FIFO entry packing live here.
package logic_unit_pkg;

    localparam int OP_W  = 3;
    localparam int MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NOT  = 3'b010,
        OP_NAND = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // r is zero-extended; result sits in [w-1:0], zero at [w], parity at [w+1]
    function automatic logic [MAX_W+1:0] pack_entry(
        input logic [MAX_W-1:0] r,
        input int unsigned      w
    );
        logic [MAX_W+1:0] e;
        e = {2'b00, r};
        e = e | ((MAX_W+2)'(~|r) << w);
        e = e | ((MAX_W+2)'(^r) << (w + 1));
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Empty head reads as all-zero.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Handshaked WIDTH-bit logic unit with accumulator chaining
// and a buffered result queue carrying zero/parity flags.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [OP_W-1:0]        op,
    input  logic                   acc_sel,
    input  logic                   acc_clr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_zero,
    output logic                   out_parity,
    output logic [WIDTH-1:0]       acc_q,
    output logic [$clog2(DEPTH):0] level
);

    logic             accept;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] res;
    logic [WIDTH+1:0] entry;
    logic [WIDTH+1:0] head;

    assign in_ready = ~full;
    assign accept   = in_valid & in_ready;
    assign opa      = acc_sel ? (acc_clr ? '0 : acc_q) : a;

    always_comb begin
        res = '0;
        case (op_e'(op))
            OP_AND:  res = opa & b;
            OP_OR:   res = opa | b;
            OP_NOT:  res = ~opa;
            OP_NAND: res = ~(opa & b);
            OP_XOR:  res = opa ^ b;
            OP_NOR:  res = ~(opa | b);
            OP_XNOR: res = ~(opa ^ b);
            OP_PASS: res = opa;
            default: res = '0;
        endcase
    end

    assign entry = (WIDTH+2)'(pack_entry(MAX_W'(res), WIDTH));

    // acc_q tracks the pushed result so acc_sel beats chain without bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= res;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

    sync_fifo #(
        .WIDTH(WIDTH + 2),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (accept),
        .wdata(entry),
        .pop  (out_ready),
        .rdata(head),
        .full (full),
        .empty(empty),
        .level(level)
    );

    assign out_valid  = ~empty;
    assign out_data   = head[WIDTH-1:0];
    assign out_zero   = head[WIDTH];
    assign out_parity = head[WIDTH+1];

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && accept) begin
            assert (!$isunknown(op));
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: 8- and 16-bit instances driven in lockstep,
// checked every cycle against a queue-based model plus literal pins.
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic        acc_sel;
    logic        acc_clr;
    logic        out_ready;

    logic        rdy8, ov8, z8, p8;
    logic [7:0]  od8, acc8;
    logic [1:0]  lvl8;
    logic        rdy16, ov16, z16, p16;
    logic [15:0] od16, acc16;
    logic [1:0]  lvl16;

    int checks = 0;
    int failures = 0;

    logic [15:0] q8[$];
    logic [15:0] q16[$];
    logic [15:0] m_acc8 = '0;
    logic [15:0] m_acc16 = '0;

    logic_unit_pipe #(.WIDTH(8), .DEPTH(2)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy8),
        .a(a[7:0]), .b(b[7:0]), .op(op),
        .acc_sel(acc_sel), .acc_clr(acc_clr),
        .out_valid(ov8), .out_ready(out_ready),
        .out_data(od8), .out_zero(z8), .out_parity(p8),
        .acc_q(acc8), .level(lvl8)
    );

    logic_unit_pipe #(.WIDTH(16), .DEPTH(2)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(rdy16),
        .a(a), .b(b), .op(op),
        .acc_sel(acc_sel), .acc_clr(acc_clr),
        .out_valid(ov16), .out_ready(out_ready),
        .out_data(od16), .out_zero(z16), .out_parity(p16),
        .acc_q(acc16), .level(lvl16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lop(
        input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
        input logic [15:0] m
    );
        logic [15:0] r;
        case (o)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: r = ~x;
            3'd3: r = ~(x & y);
            3'd4: r = x ^ y;
            3'd5: r = ~(x | y);
            3'd6: r = ~(x ^ y);
            default: r = x;
        endcase
        return r & m;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [15:0] ap;
        logic [15:0] r;
        logic        psh;
        logic        pp;
        if (!rst_n) begin
            q8.delete();
            q16.delete();
            m_acc8 <= '0;
            m_acc16 <= '0;
        end else begin
            psh = in_valid && (q8.size() != 2);
            pp  = out_ready && (q8.size() != 0);
            ap  = acc_sel ? (acc_clr ? 16'h0 : m_acc8) : (a & 16'h00FF);
            r   = lop(op, ap, b, 16'h00FF);
            if (pp) void'(q8.pop_front());
            if (psh) begin
                q8.push_back(r);
                m_acc8 <= r;
            end else if (acc_clr) begin
                m_acc8 <= '0;
            end
            psh = in_valid && (q16.size() != 2);
            pp  = out_ready && (q16.size() != 0);
            ap  = acc_sel ? (acc_clr ? 16'h0 : m_acc16) : a;
            r   = lop(op, ap, b, 16'hFFFF);
            if (pp) void'(q16.pop_front());
            if (psh) begin
                q16.push_back(r);
                m_acc16 <= r;
            end else if (acc_clr) begin
                m_acc16 <= '0;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] h;
        h = (q8.size() != 0) ? q8[0] : 16'h0;
        check("lvl8", 32'(lvl8), q8.size());
        check("ov8", 32'(ov8), 32'(q8.size() != 0));
        check("rdy8", 32'(rdy8), 32'(q8.size() != 2));
        check("data8", 32'(od8), 32'(h));
        check("zero8", 32'(z8), 32'((q8.size() != 0) && (h == 0)));
        check("par8", 32'(p8), 32'(^h));
        check("acc8", 32'(acc8), 32'(m_acc8));
        h = (q16.size() != 0) ? q16[0] : 16'h0;
        check("lvl16", 32'(lvl16), q16.size());
        check("ov16", 32'(ov16), 32'(q16.size() != 0));
        check("rdy16", 32'(rdy16), 32'(q16.size() != 2));
        check("data16", 32'(od16), 32'(h));
        check("zero16", 32'(z16), 32'((q16.size() != 0) && (h == 0)));
        check("par16", 32'(p16), 32'(^h));
        check("acc16", 32'(acc16), 32'(m_acc16));
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic beat(input logic [2:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic s, input logic c);
        int n;
        op = o; a = x; b = y; acc_sel = s; acc_clr = c; in_valid = 1'b1;
        n = 0;
        while (!rdy8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n == 40) begin
            failures++;
            $display("FAIL beat_timeout in_ready stuck low");
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0; acc_sel = 1'b0; acc_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0;
        acc_sel = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lvl", 32'(lvl8), 0);
        check("rst_ov", 32'(ov8), 0);
        check("rst_rdy", 32'(rdy8), 1);
        check("rst_acc", 32'(acc8), 0);
        rst_n = 1'b1;
        @(negedge clk);

        beat(3'd0, 16'h00F0, 16'h003C, 1'b0, 1'b0);
        idle();
        check("and_data", 32'(od8), 32'h30);
        check("and_zero", 32'(z8), 0);
        check("and_par", 32'(p8), 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_lvl", 32'(lvl8), 0);
        out_ready = 1'b0;

        beat(3'd1, 16'h0000, 16'h0001, 1'b1, 1'b1);
        beat(3'd4, 16'h0000, 16'h00FF, 1'b1, 1'b0);
        idle();
        check("acc_q", 32'(acc8), 32'hFE);
        check("acc_head", 32'(od8), 32'h01);
        out_ready = 1'b1;
        @(negedge clk);
        check("acc_second", 32'(od8), 32'hFE);
        @(negedge clk);
        out_ready = 1'b0;

        beat(3'd7, 16'h0011, 16'h0000, 1'b0, 1'b0);
        beat(3'd7, 16'h0022, 16'h0000, 1'b0, 1'b0);
        check("bp_rdy", 32'(rdy8), 0);
        check("bp_lvl", 32'(lvl8), 2);
        check("bp_head", 32'(od8), 32'h11);
        repeat (2) @(negedge clk);
        check("bp_hold", 32'(od8), 32'h11);
        out_ready = 1'b1;
        beat(3'd7, 16'h0033, 16'h0000, 1'b0, 1'b0);
        idle();
        check("bp_third", 32'(od8), 32'h33);
        @(negedge clk);
        out_ready = 1'b0;

        beat(3'd7, 16'h0040, 16'h0000, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            beat(3'(i), 16'(i * 37 + 5), 16'(16'hA55A ^ (i * 17)),
                 1'(i % 3 == 1), 1'b0);
        end
        check("stream_lvl", 32'(lvl8), 1);
        idle();
        repeat (2) @(negedge clk);
        out_ready = 1'b0;

        beat(3'd3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        idle();
        check("nand16_data", 32'(od16), 0);
        check("nand16_zero", 32'(z16), 1);
        check("nand16_par", 32'(p16), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        beat(3'd2, 16'h0000, 16'h1234, 1'b0, 1'b0);
        idle();
        check("not16_data", 32'(od16), 32'hFFFF);
        check("not16_zero", 32'(z16), 0);
        check("not16_par", 32'(p16), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        beat(3'd7, 16'h005A, 16'h0000, 1'b0, 1'b0);
        beat(3'd7, 16'h00A5, 16'h0000, 1'b0, 1'b0);
        idle();
        check("pre_rst_lvl", 32'(lvl8), 2);
        check("pre_rst_acc", 32'(acc8), 32'hA5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ov", 32'(ov8), 0);
        check("arst_lvl", 32'(lvl8), 0);
        check("arst_acc", 32'(acc8), 0);
        check("arst_acc16", 32'(acc16), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        beat(3'd6, 16'h0F0F, 16'h00FF, 1'b0, 1'b0);
        idle();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
